// File: rtl/shiftreg_pkg.sv
// Shared definitions for the serial configuration load protocol.
// Holds the default register sizes (shared by sequencer and receiver)
// and the receiver FSM state encoding.
package shiftreg_pkg;

  localparam int unsigned SIZE_SR_STAT  = 88;
  localparam int unsigned SIZE_SR_DYN   = 16;
  localparam int unsigned SIZE_ADDR_MUX = 7;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    SHIFT_DYN  = 2'b01,
    SHIFT_STAT = 2'b10,
    ERROR      = 2'b11
  } rx_state_t;

endpackage

// File: rtl/sipo_shadow.sv
// Serial-in shift register with a parallel shadow copy.
// Ports:
//   clk      - clock, all logic on posedge
//   rst      - synchronous active-high reset, clears both registers
//   shift_en - shift bit_in into the LSB (first bit ends up in the MSB)
//   bit_in   - serial data
//   commit   - copy the shift register into the shadow
//   shadow   - committed parallel word
module sipo_shadow #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             commit,
  output logic [WIDTH-1:0] shadow
);

  logic [WIDTH-1:0] shreg;

  // Shift path and shadow update; never both active for one instance.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      shadow <= '0;
    end else begin
      if (shift_en) shreg  <= {shreg[WIDTH-2:0], bit_in};
      if (commit)   shadow <= shreg;
    end
  end

endmodule

// File: rtl/shiftreg_rx.sv
// Receiver for the serial configuration load protocol. Deserialises
// signal_in into a dynamic or static shadow word depending on the active
// select, committing only frames of exactly the register length.
// Ports:
//   CLK, RST            - clock, synchronous active-high reset
//   sel_dyn, sel_stat   - frame selects (high while bits are shifted)
//   en_fin              - sequencer flag: configuration may be applied
//   signal_in           - serial data, MSB first
//   dyn_cfg, stat_cfg   - committed words
//   mux_addr            - low bits of dyn_cfg
//   dyn_upd, stat_upd   - one-cycle commit pulses
//   len_err, sel_err    - one-cycle error pulses
//   cfg_active          - en_fin qualified by a prior dynamic commit
module shiftreg_rx
  import shiftreg_pkg::*;
#(
  parameter int unsigned SIZESRSTAT  = SIZE_SR_STAT,
  parameter int unsigned SIZESRDYN   = SIZE_SR_DYN,
  parameter int unsigned SIZEADDRMUX = SIZE_ADDR_MUX
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   sel_dyn,
  input  logic                   sel_stat,
  input  logic                   en_fin,
  input  logic                   signal_in,
  output logic [SIZESRDYN-1:0]   dyn_cfg,
  output logic [SIZESRSTAT-1:0]  stat_cfg,
  output logic [SIZEADDRMUX-1:0] mux_addr,
  output logic                   dyn_upd,
  output logic                   stat_upd,
  output logic                   len_err,
  output logic                   sel_err,
  output logic                   cfg_active
);

  localparam int unsigned CNT_W = $clog2(SIZESRSTAT + 2);
  localparam logic [CNT_W-1:0] CNT_DYN_FULL  = CNT_W'(SIZESRDYN);
  localparam logic [CNT_W-1:0] CNT_DYN_SAT   = CNT_W'(SIZESRDYN + 1);
  localparam logic [CNT_W-1:0] CNT_STAT_FULL = CNT_W'(SIZESRSTAT);
  localparam logic [CNT_W-1:0] CNT_STAT_SAT  = CNT_W'(SIZESRSTAT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             dyn_seen;
  logic             shift_dyn;
  logic             shift_stat;
  logic             commit_dyn;
  logic             commit_stat;

  // A register shifts whenever only its own select is high outside ERROR;
  // this covers frame entry, continuation and direct handoff alike.
  always_comb begin
    shift_dyn   = 1'b0;
    shift_stat  = 1'b0;
    commit_dyn  = 1'b0;
    commit_stat = 1'b0;
    if (state != ERROR) begin
      shift_dyn  = sel_dyn & ~sel_stat;
      shift_stat = sel_stat & ~sel_dyn;
    end
    commit_dyn  = (state == SHIFT_DYN)  & ~sel_dyn  & (cnt == CNT_DYN_FULL);
    commit_stat = (state == SHIFT_STAT) & ~sel_stat & (cnt == CNT_STAT_FULL);
  end

  sipo_shadow #(.WIDTH(SIZESRDYN)) u_dyn (
    .clk      (CLK),
    .rst      (RST),
    .shift_en (shift_dyn),
    .bit_in   (signal_in),
    .commit   (commit_dyn),
    .shadow   (dyn_cfg)
  );

  sipo_shadow #(.WIDTH(SIZESRSTAT)) u_stat (
    .clk      (CLK),
    .rst      (RST),
    .shift_en (shift_stat),
    .bit_in   (signal_in),
    .commit   (commit_stat),
    .shadow   (stat_cfg)
  );

  assign mux_addr = dyn_cfg[SIZEADDRMUX-1:0];

  // Frame FSM, shared bit counter and registered status pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      dyn_seen   <= 1'b0;
      cfg_active <= 1'b0;
      dyn_upd    <= 1'b0;
      stat_upd   <= 1'b0;
      len_err    <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      dyn_upd    <= 1'b0;
      stat_upd   <= 1'b0;
      len_err    <= 1'b0;
      sel_err    <= 1'b0;
      cfg_active <= en_fin & dyn_seen;
      case (state)
        IDLE: begin
          if (sel_dyn && sel_stat) begin
            state   <= ERROR;
            sel_err <= 1'b1;
          end else if (sel_dyn) begin
            state <= SHIFT_DYN;
            cnt   <= CNT_ONE;
          end else if (sel_stat) begin
            state <= SHIFT_STAT;
            cnt   <= CNT_ONE;
          end
        end
        SHIFT_DYN: begin
          if (sel_dyn) begin
            if (sel_stat) begin
              state   <= ERROR;
              sel_err <= 1'b1;
            end else if (cnt != CNT_DYN_SAT) begin
              cnt <= cnt + CNT_ONE;
            end
          end else begin
            if (commit_dyn) begin
              dyn_upd  <= 1'b1;
              dyn_seen <= 1'b1;
            end else begin
              len_err <= 1'b1;
            end
            if (sel_stat) begin
              state <= SHIFT_STAT;
              cnt   <= CNT_ONE;
            end else begin
              state <= IDLE;
            end
          end
        end
        SHIFT_STAT: begin
          if (sel_stat) begin
            if (sel_dyn) begin
              state   <= ERROR;
              sel_err <= 1'b1;
            end else if (cnt != CNT_STAT_SAT) begin
              cnt <= cnt + CNT_ONE;
            end
          end else begin
            if (commit_stat) stat_upd <= 1'b1;
            else             len_err  <= 1'b1;
            if (sel_dyn) begin
              state <= SHIFT_DYN;
              cnt   <= CNT_ONE;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          if (!sel_dyn && !sel_stat) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shiftreg_rx.sv
// Self-checking bench for shiftreg_rx: directed protocol scenarios plus
// randomized frames, compared every cycle against a queue-based model.
module tb_shiftreg_rx;

  localparam int unsigned SD = 16;
  localparam int unsigned SS = 88;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          sel_dyn = 1'b0;
  logic          sel_stat = 1'b0;
  logic          en_fin = 1'b0;
  logic          signal_in = 1'b0;
  logic [SD-1:0] dyn_cfg;
  logic [SS-1:0] stat_cfg;
  logic [6:0]    mux_addr;
  logic          dyn_upd, stat_upd, len_err, sel_err, cfg_active;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: mode 0 idle, 1 dyn frame, 2 stat frame, 3 error.
  int            m_mode = 0;
  bit            m_q[$];
  logic [SD-1:0] m_dyn = '0;
  logic [SS-1:0] m_stat = '0;
  logic          m_dupd = 0, m_supd = 0, m_lerr = 0, m_serr = 0;
  logic          m_seen = 0, m_act = 0;

  shiftreg_rx dut (
    .CLK        (CLK),
    .RST        (RST),
    .sel_dyn    (sel_dyn),
    .sel_stat   (sel_stat),
    .en_fin     (en_fin),
    .signal_in  (signal_in),
    .dyn_cfg    (dyn_cfg),
    .stat_cfg   (stat_cfg),
    .mux_addr   (mux_addr),
    .dyn_upd    (dyn_upd),
    .stat_upd   (stat_upd),
    .len_err    (len_err),
    .sel_err    (sel_err),
    .cfg_active (cfg_active)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h required %0h (t=%0t)", tag, got, exp, $time);
    else
      n_pass++;
  endtask

  // A frame is kept only if it holds exactly the register length in bits;
  // bit i of the queue lands at position SIZE-1-i.
  task automatic model_finish(input int kind);
    int sz;
    sz = (kind == 1) ? SD : SS;
    if (m_q.size() == sz) begin
      if (kind == 1) begin
        for (int i = 0; i < SD; i++) m_dyn[SD-1-i] = m_q[i];
        m_dupd = 1'b1;
        m_seen = 1'b1;
      end else begin
        for (int i = 0; i < SS; i++) m_stat[SS-1-i] = m_q[i];
        m_supd = 1'b1;
      end
    end else begin
      m_lerr = 1'b1;
    end
    m_q.delete();
  endtask

  task automatic model_step(input logic r, input logic sd, input logic ss,
                            input logic si, input logic ef);
    logic new_act;
    m_dupd = 0; m_supd = 0; m_lerr = 0; m_serr = 0;
    if (r) begin
      m_mode = 0; m_q.delete();
      m_dyn = '0; m_stat = '0; m_seen = 0; m_act = 0;
    end else begin
      new_act = ef & m_seen;
      case (m_mode)
        0: begin
          if (sd && ss) begin m_mode = 3; m_serr = 1; end
          else if (sd) begin m_q.delete(); m_q.push_back(si); m_mode = 1; end
          else if (ss) begin m_q.delete(); m_q.push_back(si); m_mode = 2; end
        end
        1: begin
          if (sd && ss) begin m_mode = 3; m_serr = 1; m_q.delete(); end
          else if (sd) m_q.push_back(si);
          else begin
            model_finish(1);
            if (ss) begin m_q.push_back(si); m_mode = 2; end
            else m_mode = 0;
          end
        end
        2: begin
          if (sd && ss) begin m_mode = 3; m_serr = 1; m_q.delete(); end
          else if (ss) m_q.push_back(si);
          else begin
            model_finish(2);
            if (sd) begin m_q.push_back(si); m_mode = 1; end
            else m_mode = 0;
          end
        end
        default: if (!sd && !ss) m_mode = 0;
      endcase
      m_act = new_act;
    end
  endtask

  // Drive one cycle, advance the model on the same edge, compare all outputs.
  task automatic step(input logic r, input logic sd, input logic ss, input logic si);
    RST = r; sel_dyn = sd; sel_stat = ss; signal_in = si;
    @(posedge CLK);
    #1;
    model_step(r, sd, ss, si, en_fin);
    check("dyn_cfg",    dyn_cfg,    m_dyn);
    check("stat_cfg",   stat_cfg,   m_stat);
    check("mux_addr",   mux_addr,   m_dyn[6:0]);
    check("dyn_upd",    dyn_upd,    m_dupd);
    check("stat_upd",   stat_upd,   m_supd);
    check("len_err",    len_err,    m_lerr);
    check("sel_err",    sel_err,    m_serr);
    check("cfg_active", cfg_active, m_act);
  endtask

  // Shift bits nbits-1-skip .. 0 of data, MSB first, with one select held.
  task automatic send_frame(input int kind, input int nbits, input logic [127:0] data,
                            input int skip);
    for (int i = skip; i < nbits; i++)
      step(1'b0, kind == 0, kind == 1, data[nbits-1-i]);
  endtask

  logic [SS-1:0]  pat1, pat2, rnd;
  logic [127:0]   rdata;

  initial begin
    pat1 = 88'hA5_0123_4567_89AB_CDEF_01_5A;
    pat2 = 88'h5A_FEDC_BA98_7654_3210_F0_A5;

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("rst_dyn_cfg", dyn_cfg, 0);
    check("rst_cfg_active", cfg_active, 0);

    // en_fin before any dynamic commit
    en_fin = 1'b1;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("en_before_commit", cfg_active, 0);
    en_fin = 1'b0;

    // Dynamic load 0x8001
    send_frame(0, 16, 128'h8001, 0);
    step(0, 0, 0, 0);
    check("dyn_load_cfg", dyn_cfg, 16'h8001);
    check("dyn_load_mux", mux_addr, 7'h01);
    check("dyn_load_upd", dyn_upd, 1);
    check("dyn_load_stat", stat_cfg, 0);
    step(0, 0, 0, 0);
    check("dyn_upd_one_cycle", dyn_upd, 0);

    // Static load
    send_frame(1, 88, 128'(pat1), 0);
    step(0, 0, 0, 0);
    check("stat_load_cfg", stat_cfg, pat1);
    check("stat_load_upd", stat_upd, 1);
    check("stat_load_dyn", dyn_cfg, 16'h8001);
    step(0, 0, 0, 0);
    check("stat_upd_one_cycle", stat_upd, 0);

    // Wrong lengths
    send_frame(0, 15, 128'h1FFF, 0);
    step(0, 0, 0, 0);
    check("len15_err", len_err, 1);
    check("len15_keep", dyn_cfg, 16'h8001);
    send_frame(0, 17, 128'h1FFFF, 0);
    step(0, 0, 0, 0);
    check("len17_err", len_err, 1);
    check("len17_keep", dyn_cfg, 16'h8001);

    // Select conflict mid dynamic frame, ERROR held until both low
    send_frame(0, 8, 128'hC3, 0);
    step(0, 1, 1, 0);
    check("conflict_sel_err", sel_err, 1);
    check("conflict_no_lenerr", len_err, 0);
    step(0, 1, 0, 1);
    step(0, 0, 1, 1);
    step(0, 0, 0, 0);
    check("conflict_no_commit", dyn_cfg, 16'h8001);

    // Direct handoff dyn -> stat
    send_frame(0, 16, 128'h00AB, 0);
    step(0, 0, 1, pat2[87]);
    check("handoff_dyn_upd", dyn_upd, 1);
    check("handoff_dyn_cfg", dyn_cfg, 16'h00AB);
    send_frame(1, 88, 128'(pat2), 1);
    step(0, 0, 0, 0);
    check("handoff_stat_cfg", stat_cfg, pat2);
    check("handoff_stat_upd", stat_upd, 1);

    // Reset mid-frame, select still high afterwards
    send_frame(0, 8, 128'h5A, 0);
    step(1, 1, 0, 0);
    check("midrst_dyn", dyn_cfg, 0);
    check("midrst_stat", stat_cfg, 0);
    check("midrst_mux", mux_addr, 0);
    send_frame(0, 16, 128'h1234, 0);
    step(0, 0, 0, 0);
    check("after_rst_dyn", dyn_cfg, 16'h1234);

    // en_fin gating after a dynamic commit
    en_fin = 1'b1;
    step(0, 0, 0, 0);
    check("en_fin_active", cfg_active, 1);
    en_fin = 1'b0;
    step(0, 0, 0, 0);
    check("en_fin_inactive", cfg_active, 0);

    // Randomized frames: near-boundary lengths, handoffs, conflicts, resets
    for (int n = 0; n < 200; n++) begin
      int kind, len, gap;
      kind = int'($urandom_range(0, 1));
      len  = (kind == 0) ? SD : SS;
      if ($urandom_range(0, 4) == 0) len = len + (($urandom_range(0, 1) == 0) ? -1 : 1);
      rnd = {$urandom, $urandom, $urandom};
      for (int i = 0; i < len; i++) begin
        logic r;
        en_fin = 1'($urandom_range(0, 1));
        r = ($urandom_range(0, 127) == 0);
        if (i == len / 2 && $urandom_range(0, 15) == 0) begin
          step(0, 1, 1, rnd[i]);
          break;
        end
        step(r, kind == 0, kind == 1, rnd[i]);
      end
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        en_fin = 1'($urandom_range(0, 1));
        step(0, 0, 0, 1'($urandom_range(0, 1)));
      end
    end
    step(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
